// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge.
// The optional bus watchdog is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } bridge_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: byte strobes, replicated write data,
// misaligned/illegal detection and the read-data shift amount.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mode,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad,
  output logic [4:0]  shift
);

  mem_size_t size;

  always_comb begin
    size  = mem_size_t'(mode[1:0]);
    be    = 4'b0000;
    wdata = data;
    bad   = 1'b1;
    shift = {addr_lo, 3'b000};
    // mode[2] set or size 2'b11 leaves bad asserted
    if (!mode[2]) begin
      case (size)
        BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{data[7:0]}};
          bad   = 1'b0;
        end
        HALF: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{data[15:0]}};
          bad   = addr_lo[0];
        end
        WORD: begin
          be    = 4'b1111;
          bad   = (addr_lo != 2'b00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-memory port to word-wide req/ack bus bridge.
// Define DMEM_BRIDGE_TIMEOUT_EN to add the bus watchdog and the bus_timeout output.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_enable,
  input  logic [ADDR_W-1:0] core_address,
  input  logic [31:0]       core_write_data,
  input  logic              core_write_enable,
  input  logic [2:0]        core_write_mode,
  input  logic              core_read_enable,
  input  logic [2:0]        core_read_mode,
  output logic [31:0]       core_read_data,
  output logic              core_wait,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  ,
  output logic              bus_timeout
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake: bus_req rises the cycle after a request is accepted and the
  // address/strobes/data hold until the cycle in which bus_ack is high.
  bridge_state_t state;
  logic [4:0]    rd_shift;
  logic [31:0]   hold;
  logic [31:0]   rd_shifted;
  logic          accept;
  logic          take;
  logic          ack_cycle;
  logic [2:0]    req_mode;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic          al_bad;
  logic [4:0]    al_shift;
  logic          unused_mode_bit;

  assign unused_mode_bit = core_read_mode[2];

  assign accept     = core_enable && (core_write_enable || core_read_enable);
  assign ack_cycle  = (state == BUS) && bus_ack;
  // Requests arriving while stalled in BUS are ignored; only the ack cycle can chain.
  assign take       = accept && ((state == IDLE) || bus_ack);
  assign req_mode   = core_write_enable ? core_write_mode : {1'b0, core_read_mode[1:0]};
  assign rd_shifted = bus_rdata >> rd_shift;

  assign core_wait      = (state == BUS) && !bus_ack;
  assign core_read_data = (ack_cycle && !bus_we) ? rd_shifted : hold;

  dmem_align u_align (
    .addr_lo (core_address[1:0]),
    .mode    (req_mode),
    .data    (core_write_data),
    .be      (al_be),
    .wdata   (al_wdata),
    .bad     (al_bad),
    .shift   (al_shift)
  );

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
      misaligned <= 1'b0;
      hold       <= '0;
      rd_shift   <= '0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt         <= '0;
      bus_timeout <= 1'b0;
`endif
    end else begin
      misaligned <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      bus_timeout <= 1'b0;
`endif
      if (ack_cycle && !bus_we)
        hold <= rd_shifted;
      if (take) begin
        if (al_bad) begin
          misaligned <= 1'b1;
          state      <= IDLE;
          bus_req    <= 1'b0;
          if (!core_write_enable)
            hold <= '0;
        end else begin
          state     <= BUS;
          bus_req   <= 1'b1;
          bus_we    <= core_write_enable;
          bus_addr  <= {core_address[ADDR_W-1:2], 2'b00};
          bus_wdata <= al_wdata;
          bus_be    <= al_be;
          rd_shift  <= al_shift;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
      end else if (ack_cycle) begin
        state   <= IDLE;
        bus_req <= 1'b0;
      end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      else if (state == BUS) begin
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          bus_req     <= 1'b0;
          bus_timeout <= 1'b1;
          if (!bus_we)
            hold <= TIMEOUT_DATA;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge; define DMEM_BRIDGE_TIMEOUT_EN to also
// exercise the bus watchdog (instantiated with TIMEOUT_CYCLES=4).
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_enable;
  logic [31:0] core_address;
  logic [31:0] core_write_data;
  logic        core_write_enable;
  logic [2:0]  core_write_mode;
  logic        core_read_enable;
  logic [2:0]  core_read_mode;
  logic [31:0] core_read_data;
  logic        core_wait;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic        bus_timeout;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_hold = 32'h0;

  dmem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .core_enable       (core_enable),
    .core_address      (core_address),
    .core_write_data   (core_write_data),
    .core_write_enable (core_write_enable),
    .core_write_mode   (core_write_mode),
    .core_read_enable  (core_read_enable),
    .core_read_mode    (core_read_mode),
    .core_read_data    (core_read_data),
    .core_wait         (core_wait),
    .misaligned        (misaligned),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_be            (bus_be),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata)
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    ,
    .bus_timeout       (bus_timeout)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] mode);
    case (mode)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input int bytes, input int a);
    logic [3:0] m;
    m = 4'((1 << bytes) - 1);
    return m << a;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int bytes);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % bytes) +: 8];
    return r;
  endfunction

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    core_enable = 1'b0;
    core_write_enable = 1'b0;
    core_read_enable = 1'b0;
  endtask

  task automatic present(input bit we, input bit re, input logic [2:0] wmode,
                         input logic [2:0] rmode, input logic [31:0] addr,
                         input logic [31:0] wd);
    core_enable       = 1'b1;
    core_write_enable = we;
    core_read_enable  = re;
    core_write_mode   = wmode;
    core_read_mode    = rmode;
    core_address      = addr;
    core_write_data   = wd;
  endtask

  // One complete access: present at a negedge, respond ack_delay cycles after bus_req.
  task automatic do_access(input string tag, input bit we, input bit re,
                           input logic [2:0] wmode, input logic [2:0] rmode,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_delay, input logic [31:0] rdata);
    logic [2:0] mode;
    int bytes, a, waits;
    bit bad;
    logic [31:0] got_rd;
    mode  = we ? wmode : {1'b0, rmode[1:0]};
    bytes = size_bytes(mode);
    a     = int'(addr[1:0]);
    bad   = (bytes == 0) || ((a % bytes) != 0);
    @(negedge clk);
    present(we, re, wmode, rmode, addr, wd);
    @(negedge clk);
    idle_inputs();
    if (!we && !re) begin
      checks++;
      if (bus_req !== 1'b0 || misaligned !== 1'b0 || core_wait !== 1'b0) begin
        errors++;
        $display("FAIL %s no_txn: req=%b mis=%b wait=%b expected 0 0 0", tag, bus_req, misaligned, core_wait);
      end
      return;
    end
    if (bad) begin
      if (!we) model_hold = 32'h0;
      chk({tag, " misaligned"}, {31'h0, misaligned}, 32'h1);
      chk({tag, " drop_req"}, {31'h0, bus_req}, 32'h0);
      chk({tag, " drop_wait"}, {31'h0, core_wait}, 32'h0);
      chk({tag, " drop_hold"}, core_read_data, model_hold);
      @(negedge clk);
      chk({tag, " mis_pulse_end"}, {31'h0, misaligned}, 32'h0);
      return;
    end
    if (!we) exp_q.push_back(rdata >> (8 * a));
    chk({tag, " req"}, {31'h0, bus_req}, 32'h1);
    chk({tag, " we"}, {31'h0, bus_we}, {31'h0, we});
    chk({tag, " addr"}, bus_addr, {addr[31:2], 2'b00});
    chk({tag, " be"}, {28'h0, bus_be}, {28'h0, exp_be(bytes, a)});
    if (we) chk({tag, " wdata"}, bus_wdata, exp_wdata(wd, bytes));
    waits = 0;
    for (int k = 0; k <= ack_delay; k++) begin
      if (k == ack_delay) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
        #1;
        chk({tag, " wait_at_ack"}, {31'h0, core_wait}, 32'h0);
        if (!we) begin
          got_rd = core_read_data;
          model_hold = exp_q.pop_front();
          chk({tag, " rdata_ack"}, got_rd, model_hold);
        end
      end else begin
        bus_rdata = $urandom;
        #1;
        if (core_wait) waits++;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    #1;
    chk({tag, " wait_cycles"}, waits, ack_delay);
    chk({tag, " req_done"}, {31'h0, bus_req}, 32'h0);
    chk({tag, " hold"}, core_read_data, model_hold);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    core_address = '0; core_write_data = '0; core_write_mode = '0; core_read_mode = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {bus_req, bus_we, core_wait, misaligned, bus_be}, 8'h0);
    chk("reset addr", bus_addr, 32'h0);
    chk("reset wdata", bus_wdata, 32'h0);
    chk("reset rdata", core_read_data, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    do_access("word_store", 1, 0, 3'd2, 3'd0, 32'h0000_0104, 32'h1122_3344, 2, 32'h0);
    do_access("byte_load", 0, 1, 3'd0, 3'd0, 32'h0000_0203, 32'h0, 0, 32'hAB00_0000);
    do_access("half_store", 1, 0, 3'd1, 3'd0, 32'h0000_0012, 32'h0000_BEEF, 1, 32'h0);
    do_access("half_load_mis", 0, 1, 3'd0, 3'd1, 32'h0000_0013, 32'h0, 0, 32'h0);
    do_access("illegal_wmode", 1, 0, 3'd5, 3'd0, 32'h0000_0020, 32'h55, 0, 32'h0);
    do_access("both_en_write_wins", 1, 1, 3'd0, 3'd2, 32'h0000_0031, 32'h0000_00C3, 1, 32'h0);
    do_access("neither_en", 0, 0, 3'd2, 3'd2, 32'h0000_0040, 32'h0, 0, 32'h0);
    do_access("half_load_hi", 0, 1, 3'd0, 3'd5, 32'h0000_0052, 32'h0, 3, 32'hCAFE_1234);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    @(negedge clk);
    present(1, 0, 3'd2, 3'd0, 32'h0000_0200, 32'hA5A5_0F0F);
    @(negedge clk);
    idle_inputs();
    chk("b2b store req", {31'h0, bus_req}, 32'h1);
    @(negedge clk);
    bus_ack = 1'b1;
    present(0, 1, 3'd0, 3'd1, 32'h0000_0306, 32'h0);
    @(negedge clk);
    idle_inputs();
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    #1;
    chk("b2b no gap", {31'h0, bus_req}, 32'h1);
    chk("b2b load we", {31'h0, bus_we}, 32'h0);
    chk("b2b load addr", bus_addr, 32'h0000_0304);
    chk("b2b load be", {28'h0, bus_be}, 32'hC);
    chk("b2b wait", {31'h0, core_wait}, 32'h1);
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'h7788_99AA;
    exp_rd = 32'h7788_99AA >> 16;
    #1;
    chk("b2b rdata", core_read_data, exp_rd);
    model_hold = exp_rd;
    @(negedge clk);
    bus_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_rdata = $urandom;
      #1;
      chk("b2b hold", core_read_data, model_hold);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit we, re;
      int sel;
      logic [2:0] wm, rm;
      sel = $urandom_range(0, 9);
      we  = (sel <= 4);
      re  = (sel >= 4 && sel <= 8);
      wm  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rm  = 3'($urandom_range(0, 7));
      do_access("random", we, re, wm, rm, $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end
  endtask

  task automatic test_reset_mid_bus();
    do_access("pre_reset_load", 0, 1, 3'd0, 3'd2, 32'h0000_0400, 32'h0, 0, 32'h1357_9BDF);
    @(negedge clk);
    present(0, 1, 3'd0, 3'd2, 32'h0000_0500, 32'h0);
    @(negedge clk);
    idle_inputs();
    chk("mid_bus req", {31'h0, bus_req}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async req drop", {31'h0, bus_req}, 32'h0);
    chk("async wait drop", {31'h0, core_wait}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_hold = 32'h0;
    @(negedge clk);
    chk("post_reset rdata", core_read_data, 32'h0);
    bus_ack = 1'b1;
    #1;
    chk("post_reset idle wait", {31'h0, core_wait}, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0;
    chk("post_reset idle req", {31'h0, bus_req}, 32'h0);
  endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int waits;
    @(negedge clk);
    present(0, 1, 3'd0, 3'd2, 32'h0000_0600, 32'h0);
    @(negedge clk);
    idle_inputs();
    waits = 0;
    for (int k = 0; k < 4; k++) begin
      if (core_wait && !bus_timeout) waits++;
      @(negedge clk);
    end
    chk("timeout wait cycles", waits, 4);
    chk("timeout pulse", {31'h0, bus_timeout}, 32'h1);
    chk("timeout req", {31'h0, bus_req}, 32'h0);
    chk("timeout wait", {31'h0, core_wait}, 32'h0);
    chk("timeout data", core_read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("timeout pulse end", {31'h0, bus_timeout}, 32'h0);
    model_hold = 32'hDEAD_BEEF;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the core's data-memory port and drives a word-wide req/ack system bus toward SRAM and peripherals.
- Captures the core's request during the core's execute cycle.
- Produces byte strobes and lane-replicated write data for the bus.
- Returns read data right-justified; the core's writeback stage performs sign/zero extension.
- Asserts wait until the bus acknowledges, which stalls the core pipeline.

Parameters:
- ADDR_W, 32, core/bus byte-address width (bus_addr low 2 bits always 0).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous assert, active-low
- core_enable  in  1  core pipe enable; request valid this cycle
- core_address  in  ADDR_W  byte address
- core_write_data  in  32  store data, right-justified
- core_write_enable  in  1  store request
- core_write_mode  in  3  000 byte, 001 half, 010 word; others illegal
- core_read_enable  in  1  load request
- core_read_mode  in  3  load size, same encoding in bits [1:0]
- core_read_data  out  32  load data shifted down to bit 0
- core_wait  out  1  stall core
- misaligned  out  1  one-cycle pulse: misaligned or illegal-mode access dropped
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte strobes
- bus_ack  in  1  transaction complete; rdata valid
- bus_rdata  in  32  read word

Behaviour:
- Reset: all outputs 0; FSM to IDLE; hold register cleared.
  - Reset assertion mid-transaction drops bus_req immediately.
  - No partial write is retried after reset.
- Accept: request captured at a rising edge when core_enable && (core_write_enable || core_read_enable).
  - If both enables are set, the write wins.
  - core_enable with neither enable set: no transaction.
- FSM states:
  - IDLE: accept -> BUS.
  - BUS: bus_req=1; bus_addr/bus_we/bus_wdata/bus_be come from registers and stay stable until bus_ack.
  - BUS with bus_ack: -> IDLE, or stay in BUS if a new request is accepted in the same cycle (back-to-back).
- Minimum latency: request at edge N; bus_req high in cycle N+1; ack may arrive in cycle N+1.
- core_wait = (state==BUS) && !bus_ack. Purely combinational from the state register and bus_ack.
- Read data path:
  - core_read_data = bus_rdata >> (8*addr[1:0]) in the ack cycle.
  - On ack the shifted value is latched into a hold register.
  - Otherwise core_read_data = hold register, so the data stays valid while the core is stalled by another source.
  - Writes leave the hold register unchanged.
- Strobes:
  - byte: 0001<<a
  - half: 0011<<a
  - word: 1111
  - where a = addr[1:0]
- Write data: byte lane replicated 4x; half replicated 2x; word unchanged.
- Misaligned access (half with a[0]=1; word with a!=0) or illegal mode:
  - no bus transaction; stays IDLE; core_wait stays 0.
  - misaligned pulses for 1 cycle.
  - a dropped load clears the hold register to 0.
- While core_wait=1, core_enable is low by construction; any request seen in BUS without ack is ignored.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - a counter clears on entry to BUS and increments each BUS cycle without ack.
  - when the counter reaches TIMEOUT_CYCLES: bus_req drops, FSM -> IDLE, core_wait releases, load data is 32'hDEAD_BEEF, and an extra output bus_timeout pulses for 1 cycle.
- Without the macro: no counter and no bus_timeout port; BUS waits indefinitely.

Decomposition:
- Package dmem_pkg holds:
  - mem_size_t enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10.
  - bridge_state_t enum: IDLE, BUS.
  - constant TIMEOUT_DATA = 32'hDEAD_BEEF.
- One natural combinational sub-module, dmem_align: takes address low bits and size; produces bus_be, replicated wdata, the misaligned/illegal flag, and the read shift.

Test Plan:
- Word store to 0x0000_0104 with data 0x1122_3344, ack 2 cycles after req -> bus_addr 0x104, be 1111, we=1; core_wait high for exactly 2 cycles.
- Byte load from 0x0000_0203 with bus_rdata 0xAB00_0000, ack same cycle as first req -> core_read_data 0x0000_00AB, be 1000, core_wait never high.
- Half store 0xBEEF to 0x12 -> be 1100, wdata 0xBEEF_BEEF; half load at 0x13 -> misaligned pulse, bus_req never asserted.
- Back-to-back: load accepted in ack cycle of prior store -> bus_req stays high with no gap; second ack returns correct data; hold value persists 5 cycles after ack with core_enable low.
- reset_n low mid-BUS -> bus_req and core_wait fall asynchronously; after release, FSM is IDLE and core_read_data is 0.
- With DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with no ack -> after 4 BUS cycles bus_timeout pulses and core_read_data is 0xDEAD_BEEF.
